// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg
//   Shared definitions for the pipelined logic unit:
//   - OP_* encodings of the eight bitwise operations
//   - gate_result(): bitwise result of an operation at MAX_WIDTH bits
//   - reduce_bits(): {XOR, OR, AND} reduction of the low w bits of a word
//   Callers zero-extend their WIDTH-bit operands to MAX_WIDTH and
//   truncate the result back, so WIDTH must not exceed MAX_WIDTH.
package logic_gate_pkg;

  localparam int MAX_WIDTH = 64;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Bitwise operation selected by op; upper bits beyond the caller's width
  // may be non-zero for inverting operations and are discarded by the caller.
  function automatic logic [MAX_WIDTH-1:0] gate_result(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic [2:0]           op
  );
    logic [MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      default: r = {MAX_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // {XOR-reduce, OR-reduce, AND-reduce} over the low w bits of v.
  // Bits above w are masked: forced to 0 for XOR/OR and to 1 for AND.
  function automatic logic [2:0] reduce_bits(
    input logic [MAX_WIDTH-1:0] v,
    input int                   w
  );
    logic [MAX_WIDTH-1:0] mask;
    mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
    return {^(v & mask), |(v & mask), &(v | ~mask)};
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage
//   One pipeline slot holding {valid, data}.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     load      - slot takes in_valid/in_data this edge (computed by the
//                 ready chain in the parent: slot empty or advancing)
//     in_valid  - upstream slot (or input handshake) valid
//     in_data   - upstream data
//     valid     - registered occupancy flag
//     data      - registered payload; kept when the slot empties
module logic_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Slot register: data only moves when a valid item arrives so an emptied
  // slot still shows the last payload it carried.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= {WIDTH{1'b0}};
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe
//   Back-pressurable bitwise logic unit: applies one of eight operations to
//   IN0/IN1 and carries the result through STAGES valid/ready slots with
//   bubble collapsing. Latency is STAGES cycles with no stalls.
//   Ports:
//     CLK, RST   - clock, synchronous active-high reset
//     IN0, IN1   - operands (WIDTH bits)
//     OP         - operation select, sampled with the operands
//     IN_VALID   - input transaction offered
//     IN_READY   - input transaction accepted this cycle when IN_VALID=1
//     OUT0       - last-stage result
//     OUT_RED    - {XOR, OR, AND} reduction of OUT0
//     OUT_VALID  - OUT0/OUT_RED hold a transaction
//     OUT_READY  - consumer takes the result this cycle
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic [2:0]       OP,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT0,
  output logic [2:0]       OUT_RED,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  logic [MAX_WIDTH-1:0] op_a;
  logic [MAX_WIDTH-1:0] op_b;
  logic [WIDTH-1:0]     op_res;
  logic [MAX_WIDTH-1:0] out_wide;
  logic [STAGES-1:0]    stage_valid;
  logic [STAGES-1:0]    stage_load;
  logic [WIDTH-1:0]     stage_data [STAGES];

  // Operation mux: operands widened to the package width, result cut back.
  always_comb begin
    op_a             = {MAX_WIDTH{1'b0}};
    op_b             = {MAX_WIDTH{1'b0}};
    op_a[WIDTH-1:0]  = IN0;
    op_b[WIDTH-1:0]  = IN1;
    op_res           = WIDTH'(gate_result(op_a, op_b, OP));
  end

  // Ready chain from the output back to the input: a slot loads when it is
  // empty or when the slot after it loads (the last slot uses OUT_READY).
  // An empty slot anywhere therefore lets every slot above it move.
  always_comb begin : ready_chain
    logic chain;
    chain      = OUT_READY;
    stage_load = {STAGES{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_load[k] = ~stage_valid[k] | chain;
      chain         = stage_load[k];
    end
  end

  // Nothing is accepted while reset is applied.
  assign IN_READY = stage_load[0] & ~RST;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (CLK),
        .rst      (RST),
        .load     (stage_load[k]),
        .in_valid (IN_VALID),
        .in_data  (op_res),
        .valid    (stage_valid[k]),
        .data     (stage_data[k])
      );
    end else begin : g_next
      logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (CLK),
        .rst      (RST),
        .load     (stage_load[k]),
        .in_valid (stage_valid[k-1]),
        .in_data  (stage_data[k-1]),
        .valid    (stage_valid[k]),
        .data     (stage_data[k])
      );
    end
  end

  assign OUT0      = stage_data[STAGES-1];
  assign OUT_VALID = stage_valid[STAGES-1];

  // Reduction flags over the registered result.
  always_comb begin
    out_wide            = {MAX_WIDTH{1'b0}};
    out_wide[WIDTH-1:0] = stage_data[STAGES-1];
    OUT_RED             = reduce_bits(out_wide, WIDTH);
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe
//   Directed checks on an 8-bit, 2-stage instance and randomized
//   valid/ready traffic on 5-bit instances with 1 and 4 stages, checked
//   against a truth-table/popcount reference model and an ordered queue.
module tb_logic_gate_pipe;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  // 8-bit, 2-stage instance for the directed steps
  logic [7:0] a8, b8, o8;
  logic [2:0] op8, red8;
  logic       iv8, ir8, ov8, ordy8;

  logic_gate_pipe #(.WIDTH(8), .STAGES(2)) u_w8s2 (
    .CLK(CLK), .RST(RST), .IN0(a8), .IN1(b8), .OP(op8),
    .IN_VALID(iv8), .IN_READY(ir8), .OUT0(o8), .OUT_RED(red8),
    .OUT_VALID(ov8), .OUT_READY(ordy8)
  );

  // 5-bit instances for random traffic: index 0 has 1 stage, index 1 has 4
  logic [4:0] ra [2];
  logic [4:0] rb [2];
  logic [4:0] ro [2];
  logic [2:0] rop [2];
  logic [2:0] rred [2];
  logic       riv [2];
  logic       rir [2];
  logic       rov [2];
  logic       rordy [2];

  logic_gate_pipe #(.WIDTH(5), .STAGES(1)) u_w5s1 (
    .CLK(CLK), .RST(RST), .IN0(ra[0]), .IN1(rb[0]), .OP(rop[0]),
    .IN_VALID(riv[0]), .IN_READY(rir[0]), .OUT0(ro[0]), .OUT_RED(rred[0]),
    .OUT_VALID(rov[0]), .OUT_READY(rordy[0])
  );

  logic_gate_pipe #(.WIDTH(5), .STAGES(4)) u_w5s4 (
    .CLK(CLK), .RST(RST), .IN0(ra[1]), .IN1(rb[1]), .OP(rop[1]),
    .IN_VALID(riv[1]), .IN_READY(rir[1]), .OUT0(ro[1]), .OUT_RED(rred[1]),
    .OUT_VALID(rov[1]), .OUT_READY(rordy[1])
  );

  // Reference: each operation as a 2-input truth table indexed by {a,b}.
  function automatic logic [7:0] model_op(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input int w);
    logic [3:0] tt [8];
    logic [7:0] r;
    tt = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
    r  = 8'h00;
    for (int i = 0; i < w; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  // Reference reductions from the population count.
  function automatic logic [2:0] model_red(input logic [7:0] v, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(v[i]);
    return {(ones % 2) == 1, ones != 0, ones == w};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] exp1 [8];
    logic [7:0] rv [3];
    logic [7:0] mq [2][16];
    int         head [2];
    int         tail [2];
    int         stg [2];
    logic       pstall [2];
    logic [4:0] po [2];
    int         cnt;
    logic [7:0] ev;

    exp1 = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    rv   = '{8'hFF, 8'h01, 8'h00};
    stg  = '{1, 4};

    RST = 1'b1; iv8 = 1'b0; ordy8 = 1'b0; a8 = 8'h00; b8 = 8'h00; op8 = 3'd0;
    for (int d = 0; d < 2; d++) begin
      riv[d] = 1'b0; rordy[d] = 1'b0; ra[d] = 5'd0; rb[d] = 5'd0; rop[d] = 3'd0;
      head[d] = 0; tail[d] = 0; pstall[d] = 1'b0; po[d] = 5'd0;
    end

    // Reset state
    tick; tick;
    RST = 1'b0;
    #2;
    check("rst_out_valid", ov8, 0);
    check("rst_out0", o8, 0);
    check("rst_out_red", red8, model_red(8'h00, 8));
    check("rst_in_ready", ir8, 1);
    tick;

    // All eight operations back-to-back, consumer always ready
    ordy8 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
    for (int i = 0; i < 12; i++) begin
      iv8 = (i < 8);
      op8 = i[2:0];
      #2;
      if (i < 8) check("seq_in_ready", ir8, 1);
      check("seq_out_valid", ov8, (i >= 2) && (i < 10));
      if (i >= 2 && i < 10) begin
        check("seq_out0", o8, exp1[i-2]);
        check("seq_model", o8, model_op(3'(i - 2), 8'hF0, 8'hCC, 8));
      end
      tick;
    end

    // Back-pressure: fill both slots, then a third input must wait
    ordy8 = 1'b0; iv8 = 1'b1; op8 = 3'd4; b8 = 8'h00;
    a8 = 8'h01; #2; check("bp_ready_1", ir8, 1); tick;
    a8 = 8'h02; #2; check("bp_ready_2", ir8, 1); tick;
    a8 = 8'h03;
    for (int j = 0; j < 3; j++) begin
      #2;
      check("bp_full_ready", ir8, 0);
      check("bp_hold_valid", ov8, 1);
      check("bp_hold_out0", o8, 8'h01);
      tick;
    end
    ordy8 = 1'b1;
    #2;
    check("bp_release_ready", ir8, 1);
    check("bp_out_1", o8, 8'h01);
    tick;
    iv8 = 1'b0;
    #2; check("bp_valid_2", ov8, 1); check("bp_out_2", o8, 8'h02); tick;
    #2; check("bp_valid_3", ov8, 1); check("bp_out_3", o8, 8'h03); tick;
    #2; check("bp_empty_valid", ov8, 0); check("bp_empty_hold", o8, 8'h03); tick;

    // Bubble collapse: second item enters while the output is stalled
    ordy8 = 1'b0; op8 = 3'd7; iv8 = 1'b1; a8 = 8'hAA;
    #2; check("bub_ready_1", ir8, 1); tick;
    iv8 = 1'b0;
    #2; check("bub_not_yet_valid", ov8, 0); tick;
    iv8 = 1'b1; a8 = 8'h55;
    #2;
    check("bub_accept", ir8, 1);
    check("bub_valid", ov8, 1);
    check("bub_out_1", o8, 8'hAA);
    tick;
    iv8 = 1'b0;
    #2; check("bub_full", ir8, 0); check("bub_hold", o8, 8'hAA); tick;
    ordy8 = 1'b1;
    #2; check("bub_first", o8, 8'hAA); check("bub_first_v", ov8, 1); tick;
    #2; check("bub_second", o8, 8'h55); check("bub_second_v", ov8, 1); tick;
    #2; check("bub_drained", ov8, 0); tick;

    // Reduction flags on PASS results
    op8 = 3'd7; b8 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      iv8 = (i < 3);
      a8  = (i < 3) ? rv[i] : 8'h00;
      #2;
      if (i >= 2) begin
        check("red_out0", o8, rv[i-2]);
        check("red_flags", red8, model_red(rv[i-2], 8));
      end
      tick;
    end
    iv8 = 1'b0; tick; tick;

    // Reset with two items in flight and a third offered during reset
    ordy8 = 1'b0; iv8 = 1'b1; op8 = 3'd4; b8 = 8'h00;
    a8 = 8'h11; tick;
    a8 = 8'h22; tick;
    a8 = 8'h33; RST = 1'b1; tick;
    RST = 1'b0; iv8 = 1'b0;
    #2;
    check("mrst_valid", ov8, 0);
    check("mrst_out0", o8, 0);
    check("mrst_ready", ir8, 1);
    tick;
    ordy8 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #2; check("mrst_no_stale", ov8, 0); tick;
    end

    // Random valid/ready traffic; last cycles drain with ready held high
    for (int cyc = 0; cyc < 10012; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        riv[d]   = ($urandom_range(0, 3) != 0);
        rordy[d] = ($urandom_range(0, 2) != 0);
        ra[d]    = 5'($urandom_range(0, 31));
        rb[d]    = 5'($urandom_range(0, 31));
        rop[d]   = 3'($urandom_range(0, 7));
        if (cyc >= 10000) begin
          riv[d]   = 1'b0;
          rordy[d] = 1'b1;
        end
      end
      #2;
      for (int d = 0; d < 2; d++) begin
        cnt = tail[d] - head[d];
        check("rnd_in_ready", rir[d], (cnt < stg[d]) || rordy[d]);
        if (rov[d]) check("rnd_occupied", cnt > 0, 1);
        if (pstall[d]) begin
          check("rnd_hold_valid", rov[d], 1);
          check("rnd_hold_out0", ro[d], po[d]);
        end
        if (rov[d] && rordy[d] && cnt > 0) begin
          ev = mq[d][head[d] % 16];
          check("rnd_out0", ro[d], ev);
          check("rnd_red", rred[d], model_red(ev, 5));
          head[d]++;
        end
        if (riv[d] && rir[d]) begin
          mq[d][tail[d] % 16] = model_op(rop[d], {3'b000, ra[d]}, {3'b000, rb[d]}, 5);
          tail[d]++;
        end
        pstall[d] = rov[d] && !rordy[d];
        po[d]     = ro[d];
      end
      tick;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rnd_drain_count", tail[d] - head[d], 0);
      check("rnd_drain_valid", rov[d], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
